// File: rtl/adder_op_sequencer.sv
// adder_op_sequencer: operand capture / result latch controller for an 8-bit adder.
//   A step press captures operand A from sw_data, the next press captures B.
//   One cycle later the external adder's sum/carry are latched and held.
//   In accumulate mode the held result becomes the next A (chained additions).
// Optional build macro: STEP_DEBOUNCE_EN (adds a DEB_CYCLES stable-level filter on step).
// Ports:
//   CLK100MHZ  system clock, all state on rising edge
//   reset      asynchronous active-low reset
//   step       raw push-button, asynchronous to clock
//   clear      synchronous active-high clear (same effect as reset)
//   acc_mode   accumulate select, sampled on step in S_DONE
//   sw_data    operand switches
//   sum_in     sum from external combinational adder
//   cout_in    carry from external adder
//   op_a/op_b  operands to adder and display
//   result     latched sum; cout latched carry; valid result current
//   state      FSM state code; add_count completed additions
//   ovf_sticky any carry since last chain start
module adder_op_sequencer #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned DEB_CYCLES = 1000000
) (
   input  logic              CLK100MHZ,
   input  logic              reset,
   input  logic              step,
   input  logic              clear,
   input  logic              acc_mode,
   input  logic [DATA_W-1:0] sw_data,
   input  logic [DATA_W-1:0] sum_in,
   input  logic              cout_in,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [DATA_W-1:0] result,
   output logic              cout,
   output logic              valid,
   output logic [1:0]        state,
   output logic [CNT_W-1:0]  add_count,
   output logic              ovf_sticky
);

   localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_WAIT_A = 2'd0,
      S_WAIT_B = 2'd1,
      S_ADD    = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t state_q, state_nxt;

   logic              step_s1, step_s2;
   logic              step_lvl;
   logic              step_lvl_d;
   logic              step_pulse;

   logic [DATA_W-1:0] op_a_nxt, op_b_nxt, result_nxt;
   logic              cout_nxt, valid_nxt, ovf_nxt;
   logic [CNT_W-1:0]  add_count_nxt;

   // Two-flop synchronizer for the asynchronous step input
   always_ff @(posedge CLK100MHZ or negedge reset) begin
      if (!reset) begin
         step_s1 <= 1'b0;
         step_s2 <= 1'b0;
      end else if (clear) begin
         step_s1 <= 1'b0;
         step_s2 <= 1'b0;
      end else begin
         step_s1 <= step;
         step_s2 <= step_s1;
      end
   end

`ifdef STEP_DEBOUNCE_EN
   logic [DEB_W-1:0] deb_cnt;
   logic             deb_lvl;

   // Level flips only after DEB_CYCLES consecutive cycles at the new level
   always_ff @(posedge CLK100MHZ or negedge reset) begin
      if (!reset) begin
         deb_cnt <= '0;
         deb_lvl <= 1'b0;
      end else if (clear) begin
         deb_cnt <= '0;
         deb_lvl <= 1'b0;
      end else if (step_s2 != deb_lvl) begin
         if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            deb_cnt <= '0;
            deb_lvl <= step_s2;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end else begin
         deb_cnt <= '0;
      end
   end

   assign step_lvl = deb_lvl;
`else
   logic unused_deb;
   assign unused_deb = ^DEB_W'(DEB_CYCLES);
   assign step_lvl   = step_s2;
`endif

   // Delayed copy of the level; the pulse is high for the one cycle after a rise
   always_ff @(posedge CLK100MHZ or negedge reset) begin
      if (!reset)     step_lvl_d <= 1'b0;
      else if (clear) step_lvl_d <= 1'b0;
      else            step_lvl_d <= step_lvl;
   end

   assign step_pulse = step_lvl & ~step_lvl_d;

   // State and datapath registers
   always_ff @(posedge CLK100MHZ or negedge reset) begin
      if (!reset) begin
         state_q    <= S_WAIT_A;
         op_a       <= '0;
         op_b       <= '0;
         result     <= '0;
         cout       <= 1'b0;
         valid      <= 1'b0;
         add_count  <= '0;
         ovf_sticky <= 1'b0;
      end else if (clear) begin
         state_q    <= S_WAIT_A;
         op_a       <= '0;
         op_b       <= '0;
         result     <= '0;
         cout       <= 1'b0;
         valid      <= 1'b0;
         add_count  <= '0;
         ovf_sticky <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         op_a       <= op_a_nxt;
         op_b       <= op_b_nxt;
         result     <= result_nxt;
         cout       <= cout_nxt;
         valid      <= valid_nxt;
         add_count  <= add_count_nxt;
         ovf_sticky <= ovf_nxt;
      end
   end

   // Next-state and next-register values
   always_comb begin
      state_nxt     = state_q;
      op_a_nxt      = op_a;
      op_b_nxt      = op_b;
      result_nxt    = result;
      cout_nxt      = cout;
      valid_nxt     = valid;
      add_count_nxt = add_count;
      ovf_nxt       = ovf_sticky;

      case (state_q)
         S_WAIT_A: begin
            if (step_pulse) begin
               op_a_nxt  = sw_data;
               valid_nxt = 1'b0;
               ovf_nxt   = 1'b0;
               state_nxt = S_WAIT_B;
            end
         end
         S_WAIT_B: begin
            if (step_pulse) begin
               op_b_nxt  = sw_data;
               state_nxt = S_ADD;
            end
         end
         S_ADD: begin
            // sum_in has settled one cycle after op_b was captured
            result_nxt    = sum_in;
            cout_nxt      = cout_in;
            valid_nxt     = 1'b1;
            ovf_nxt       = ovf_sticky | cout_in;
            add_count_nxt = add_count + CNT_W'(1);
            state_nxt     = S_DONE;
         end
         S_DONE: begin
            if (step_pulse) begin
               if (acc_mode) begin
                  op_a_nxt  = result;
                  valid_nxt = 1'b0;
                  state_nxt = S_WAIT_B;
               end else begin
                  state_nxt = S_WAIT_A;
               end
            end
         end
         default: state_nxt = S_WAIT_A;
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Directed self-checking bench for adder_op_sequencer (debounce disabled).
module tb_adder_op_sequencer;

   logic       CLK100MHZ = 1'b0;
   logic       reset     = 1'b0;
   logic       step      = 1'b0;
   logic       clear     = 1'b0;
   logic       acc_mode  = 1'b0;
   logic [7:0] sw_data   = 8'h00;
   logic [7:0] sum_in;
   logic       cout_in;
   logic [7:0] op_a, op_b, result;
   logic       cout, valid, ovf_sticky;
   logic [1:0] state;
   logic [7:0] add_count;

   int errors = 0;
   int checks = 0;

   always #5 CLK100MHZ = ~CLK100MHZ;

   // External combinational adder
   assign {cout_in, sum_in} = 9'(op_a) + 9'(op_b);

   adder_op_sequencer #(.DATA_W(8), .CNT_W(8), .DEB_CYCLES(8)) dut (
      .CLK100MHZ (CLK100MHZ),
      .reset     (reset),
      .step      (step),
      .clear     (clear),
      .acc_mode  (acc_mode),
      .sw_data   (sw_data),
      .sum_in    (sum_in),
      .cout_in   (cout_in),
      .op_a      (op_a),
      .op_b      (op_b),
      .result    (result),
      .cout      (cout),
      .valid     (valid),
      .state     (state),
      .add_count (add_count),
      .ovf_sticky(ovf_sticky)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One-cycle step press; returns at the negedge after the FSM has acted
   task automatic press(input logic [7:0] d);
      @(negedge CLK100MHZ);
      sw_data = d;
      step    = 1'b1;
      @(negedge CLK100MHZ);
      step = 1'b0;
      @(negedge CLK100MHZ);
      @(negedge CLK100MHZ);
   endtask

   task automatic pulse_clear();
      @(negedge CLK100MHZ);
      clear = 1'b1;
      @(negedge CLK100MHZ);
      clear = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge CLK100MHZ);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_op_a", 32'(op_a), 32'h0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_count", 32'(add_count), 32'd0);
      reset = 1'b1;
      @(negedge CLK100MHZ);

      // Basic addition 0x3C + 0x15
      press(8'h3C);
      chk("a_state", 32'(state), 32'd1);
      chk("a_op_a", 32'(op_a), 32'h3C);
      press(8'h15);
      chk("b_op_b", 32'(op_b), 32'h15);
      chk("b_state_add", 32'(state), 32'd2);
      @(negedge CLK100MHZ);
      chk("sum1_result", 32'(result), 32'h51);
      chk("sum1_cout", 32'(cout), 32'd0);
      chk("sum1_valid", 32'(valid), 32'd1);
      chk("sum1_count", 32'(add_count), 32'd1);
      chk("sum1_state", 32'(state), 32'd3);

      // Non-accumulate return, then carry case 0xF0 + 0x20
      press(8'h00);
      chk("ret_state", 32'(state), 32'd0);
      chk("ret_valid_held", 32'(valid), 32'd1);
      press(8'hF0);
      chk("a2_valid", 32'(valid), 32'd0);
      press(8'h20);
      @(negedge CLK100MHZ);
      chk("sum2_result", 32'(result), 32'h10);
      chk("sum2_cout", 32'(cout), 32'd1);
      chk("sum2_ovf", 32'(ovf_sticky), 32'd1);
      chk("sum2_count", 32'(add_count), 32'd2);
      press(8'h00);
      press(8'h10);
      chk("newchain_ovf", 32'(ovf_sticky), 32'd0);

      // Accumulate chain 1+2, +3, +4
      pulse_clear();
      chk("clr_count", 32'(add_count), 32'd0);
      chk("clr_state", 32'(state), 32'd0);
      acc_mode = 1'b1;
      press(8'h01);
      press(8'h02);
      @(negedge CLK100MHZ);
      chk("acc1_result", 32'(result), 32'h03);
      press(8'hEE);
      chk("acc1_state", 32'(state), 32'd1);
      chk("acc1_op_a", 32'(op_a), 32'h03);
      chk("acc1_valid", 32'(valid), 32'd0);
      press(8'h03);
      @(negedge CLK100MHZ);
      chk("acc2_result", 32'(result), 32'h06);
      press(8'hEE);
      chk("acc2_state", 32'(state), 32'd1);
      press(8'h04);
      @(negedge CLK100MHZ);
      chk("acc3_result", 32'(result), 32'h0A);
      chk("acc3_count", 32'(add_count), 32'd3);
      acc_mode = 1'b0;

      // Clear coincident with a B-capture pulse
      pulse_clear();
      press(8'h55);
      chk("clrb_pre_state", 32'(state), 32'd1);
      @(negedge CLK100MHZ);
      sw_data = 8'h77;
      step    = 1'b1;
      @(negedge CLK100MHZ);
      step = 1'b0;
      @(negedge CLK100MHZ);
      clear = 1'b1;
      @(negedge CLK100MHZ);
      clear = 1'b0;
      chk("clrb_state", 32'(state), 32'd0);
      chk("clrb_op_a", 32'(op_a), 32'h0);
      chk("clrb_op_b", 32'(op_b), 32'h0);
      repeat (4) @(negedge CLK100MHZ);
      chk("clrb_later_state", 32'(state), 32'd0);

      // Held step gives one capture only
      @(negedge CLK100MHZ);
      sw_data = 8'h42;
      step    = 1'b1;
      repeat (100) @(negedge CLK100MHZ);
      step = 1'b0;
      repeat (3) @(negedge CLK100MHZ);
      chk("hold_state", 32'(state), 32'd1);
      chk("hold_op_a", 32'(op_a), 32'h42);

      // Asynchronous reset mid-cycle
      @(posedge CLK100MHZ);
      #2 reset = 1'b0;
      #1;
      chk("async_state", 32'(state), 32'd0);
      chk("async_op_a", 32'(op_a), 32'h0);
      chk("async_valid", 32'(valid), 32'd0);
      chk("async_count", 32'(add_count), 32'd0);
      @(negedge CLK100MHZ);
      reset = 1'b1;
      repeat (2) @(negedge CLK100MHZ);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
